// File: rtl/aiso_sync_bank.sv
// Asynchronous-input conditioning: reset-release sequencer plus a bank of
// synchronised, optionally debounced input channels with edge pulses.
module aiso_sync_bank #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter logic [CHANNELS-1:0] RESET_VAL = '0
) (
    input  logic                clock,
    input  logic                a_reset,
    input  logic [CHANNELS-1:0] async_in,
    output logic                s_reset,
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned DEB_W  = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [HOLD_W:0]  HOLD_END = (HOLD_W + 1)'(HOLD_CYCLES);
    localparam logic [DEB_W-1:0] DEB_END  = DEB_W'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        RST,
        SYNC,
        HOLD,
        RUN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [SYNC_STAGES-1:0]  rst_chain;
    logic [SYNC_STAGES-1:0]  rst_chain_next;
    logic [HOLD_W-1:0]       hold_cnt;
    logic [HOLD_W-1:0]       hold_cnt_next;

    logic [CHANNELS-1:0]     ch_chain [SYNC_STAGES];
    logic [CHANNELS-1:0]     sample;
    logic [DEB_W-1:0]        cnt [CHANNELS];

    assign sample = ch_chain[SYNC_STAGES-1];

    always_ff @(posedge clock or posedge a_reset) begin
        if (a_reset) begin
            state     <= RST;
            rst_chain <= '0;
            hold_cnt  <= '0;
            s_reset   <= 1'b1;
        end else begin
            state     <= state_next;
            rst_chain <= rst_chain_next;
            hold_cnt  <= hold_cnt_next;
            s_reset   <= (state_next != RUN);
        end
    end

    // Exit SYNC on the edge that fills the last chain flop, so release
    // lands exactly SYNC_STAGES+HOLD_CYCLES edges after a_reset falls.
    always_comb begin
        state_next     = state;
        hold_cnt_next  = hold_cnt;
        rst_chain_next = {rst_chain[SYNC_STAGES-2:0], 1'b1};
        case (state)
            RST: begin
                state_next = SYNC;
            end
            SYNC: begin
                hold_cnt_next = '0;
                if (rst_chain_next[SYNC_STAGES-1]) begin
                    state_next = (HOLD_CYCLES == 0) ? RUN : HOLD;
                end
            end
            HOLD: begin
                if (({1'b0, hold_cnt} + (HOLD_W + 1)'(1)) == HOLD_END) begin
                    state_next = RUN;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = RST;
            end
        endcase
    end

    always_ff @(posedge clock or posedge a_reset) begin
        if (a_reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                ch_chain[s] <= RESET_VAL;
            end
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                cnt[c] <= '0;
            end
            sync_out   <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
        end else begin
            if (state != RST) begin
                ch_chain[0] <= async_in;
                for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                    ch_chain[s] <= ch_chain[s-1];
                end
            end
            rise_pulse <= '0;
            fall_pulse <= '0;
            if (state != RUN) begin
                sync_out <= RESET_VAL;
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    cnt[c] <= '0;
                end
            end else begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if (sample[c] == sync_out[c]) begin
                        cnt[c] <= '0;
                    end else if (cnt[c] == DEB_END) begin
                        sync_out[c]   <= sample[c];
                        rise_pulse[c] <= sample[c];
                        fall_pulse[c] <= ~sample[c];
                        cnt[c]        <= '0;
                    end else begin
                        cnt[c] <= cnt[c] + DEB_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_aiso_sync_bank.sv
// Directed bench for aiso_sync_bank: several parameterisations share one
// clock and reset; vector table plus hand-written multi-cycle sequences.
module tb_aiso_sync_bank;

    logic       clock = 1'b0;
    logic       a_reset;
    logic [3:0] a_in, b_in, d_in;
    logic [0:0] c_in;

    logic       a_srst, b_srst, c_srst, d_srst;
    logic [3:0] a_sync, a_rise, a_fall;
    logic [3:0] b_sync, b_rise, b_fall;
    logic [3:0] d_sync, d_rise, d_fall;
    logic [0:0] c_sync, c_rise, c_fall;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    aiso_sync_bank dut_a (
        .clock(clock), .a_reset(a_reset), .async_in(a_in), .s_reset(a_srst),
        .sync_out(a_sync), .rise_pulse(a_rise), .fall_pulse(a_fall)
    );

    aiso_sync_bank #(.DEBOUNCE_CYCLES(3)) dut_b (
        .clock(clock), .a_reset(a_reset), .async_in(b_in), .s_reset(b_srst),
        .sync_out(b_sync), .rise_pulse(b_rise), .fall_pulse(b_fall)
    );

    aiso_sync_bank #(.SYNC_STAGES(3), .HOLD_CYCLES(0), .CHANNELS(1)) dut_c (
        .clock(clock), .a_reset(a_reset), .async_in(c_in), .s_reset(c_srst),
        .sync_out(c_sync), .rise_pulse(c_rise), .fall_pulse(c_fall)
    );

    aiso_sync_bank #(.RESET_VAL(4'hF)) dut_d (
        .clock(clock), .a_reset(a_reset), .async_in(d_in), .s_reset(d_srst),
        .sync_out(d_sync), .rise_pulse(d_rise), .fall_pulse(d_fall)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] sync;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Walks edges 1..7 after a_reset falls; a_first is dut_a's expected
    // sync_out/rise_pulse on its first RUN edge (edge 7).
    task automatic release_check(input logic [3:0] a_first);
        for (int e = 1; e <= 7; e++) begin
            @(negedge clock);
            chk($sformatf("a_srst_e%0d", e), 32'(a_srst), 32'(e < 6));
            chk($sformatf("b_srst_e%0d", e), 32'(b_srst), 32'(e < 6));
            chk($sformatf("c_srst_e%0d", e), 32'(c_srst), 32'(e < 3));
            chk($sformatf("d_srst_e%0d", e), 32'(d_srst), 32'(e < 6));
            chk($sformatf("a_sync_e%0d", e), 32'(a_sync), (e == 7) ? 32'(a_first) : 32'h0);
            chk($sformatf("a_rise_e%0d", e), 32'(a_rise), (e == 7) ? 32'(a_first) : 32'h0);
            chk($sformatf("a_fall_e%0d", e), 32'(a_fall), 32'h0);
            chk($sformatf("d_sync_e%0d", e), 32'(d_sync), 32'hF);
            chk($sformatf("d_pulse_e%0d", e), 32'({d_rise, d_fall}), 32'h0);
        end
    endtask

    initial begin
        vecs[0] = '{4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1] = '{4'h4, 4'h0, 4'h0, 4'h0};
        vecs[2] = '{4'h4, 4'h0, 4'h0, 4'h0};
        vecs[3] = '{4'h4, 4'h4, 4'h4, 4'h0};
        vecs[4] = '{4'h4, 4'h4, 4'h0, 4'h0};
        vecs[5] = '{4'h1, 4'h4, 4'h0, 4'h0};
        vecs[6] = '{4'h5, 4'h4, 4'h0, 4'h0};
        vecs[7] = '{4'h5, 4'h1, 4'h1, 4'h4};
        vecs[8] = '{4'h5, 4'h5, 4'h4, 4'h0};
        vecs[9] = '{4'h5, 4'h5, 4'h0, 4'h0};

        a_reset = 1'b1;
        a_in = 4'h0;
        b_in = 4'h0;
        c_in = 1'b0;
        d_in = 4'hF;

        #1;
        chk("rst_a_srst", 32'(a_srst), 32'h1);
        chk("rst_c_srst", 32'(c_srst), 32'h1);
        chk("rst_a_sync", 32'(a_sync), 32'h0);
        chk("rst_a_pulse", 32'({a_rise, a_fall}), 32'h0);
        chk("rst_d_sync", 32'(d_sync), 32'hF);

        repeat (3) @(negedge clock);
        a_reset = 1'b0;
        release_check(4'h0);

        // No-debounce vector table on dut_a (2-edge latency)
        for (int i = 0; i < 10; i++) begin
            a_in = vecs[i].a;
            @(negedge clock);
            chk($sformatf("vec%0d_sync", i), 32'(a_sync), 32'(vecs[i].sync));
            chk($sformatf("vec%0d_rise", i), 32'(a_rise), 32'(vecs[i].rise));
            chk($sformatf("vec%0d_fall", i), 32'(a_fall), 32'(vecs[i].fall));
        end

        // Mid-operation 2 ns reset glitch between edges
        #2 a_reset = 1'b1;
        #1;
        chk("glitch_a_srst", 32'(a_srst), 32'h1);
        chk("glitch_a_sync", 32'(a_sync), 32'h0);
        chk("glitch_d_sync", 32'(d_sync), 32'hF);
        chk("glitch_c_srst", 32'(c_srst), 32'h1);
        #1 a_reset = 1'b0;
        release_check(4'h5);

        // Drop all, then simultaneous rise on every channel
        a_in = 4'h0;
        repeat (2) @(negedge clock);
        chk("drop_sync_pre", 32'(a_sync), 32'h5);
        @(negedge clock);
        chk("drop_sync", 32'(a_sync), 32'h0);
        chk("drop_fall", 32'(a_fall), 32'h5);
        a_in = 4'hF;
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            chk($sformatf("all_sync_%0d", j), 32'(a_sync), (j >= 2) ? 32'hF : 32'h0);
            chk($sformatf("all_rise_%0d", j), 32'(a_rise), (j == 2) ? 32'hF : 32'h0);
            chk($sformatf("all_fall_%0d", j), 32'(a_fall), 32'h0);
            chk($sformatf("all_d_pulse_%0d", j), 32'({d_rise, d_fall}), 32'h0);
        end

        // Debounce: 3-cycle glitch is rejected
        for (int j = 0; j < 8; j++) begin
            b_in[0] = (j < 3);
            @(negedge clock);
            chk($sformatf("glitch3_sync_%0d", j), 32'(b_sync), 32'h0);
            chk($sformatf("glitch3_pulse_%0d", j), 32'({b_rise, b_fall}), 32'h0);
        end

        // Debounce: 4-cycle level accepted at k+5, released at k+9
        for (int j = 0; j < 11; j++) begin
            b_in[0] = (j < 4);
            @(negedge clock);
            chk($sformatf("deb_sync_%0d", j), 32'(b_sync), 32'(j >= 5 && j <= 8));
            chk($sformatf("deb_rise_%0d", j), 32'(b_rise), 32'(j == 5));
            chk($sformatf("deb_fall_%0d", j), 32'(b_fall), 32'(j == 9));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aiso_sync_bank.md
# aiso_sync_bank

Parametrised asynchronous-input conditioning block for the UART system top level. It generates a reset-release sequence with configurable synchroniser depth and a hold-off stretch. It also synchronises and optionally debounces a bank of asynchronous inputs such as buttons, switches and the raw UART RX line, and produces one-cycle edge pulses. It sits directly after the board pins and feeds the system reset and the clean inputs to the processor, UART and I/O logic.

## Interface
- SYNC_STAGES, 2: synchroniser flop count for the reset chain and for each input channel; legal range 2..4.
- HOLD_CYCLES, 4: extra cycles `s_reset` stays high after the reset chain fills; 0 is legal.
- CHANNELS, 4: number of asynchronous input channels; legal range 1..16.
- DEBOUNCE_CYCLES, 0: count for debounce; 0 means no debounce (see Operation).
- RESET_VAL, {CHANNELS{1'b0}}: per-channel value of `sync_out` while reset is active.
- clock  in  1  system clock.
- a_reset  in  1  reset, asynchronous, active-high.
- async_in  in  CHANNELS  asynchronous raw inputs.
- s_reset  out  1  synchronised system reset, active-high.
- sync_out  out  CHANNELS  synchronised, debounced levels.
- rise_pulse  out  CHANNELS  one-cycle pulse when `sync_out[i]` rises.
- fall_pulse  out  CHANNELS  one-cycle pulse when `sync_out[i]` falls.

## Operation
- Reset sequencer FSM states:
  - RST: `a_reset` is high.
  - SYNC: a 1 shifts through the SYNC_STAGES chain.
  - HOLD: the hold counter runs.
  - RUN.
- Transitions:
  - RST→SYNC when `a_reset` falls.
  - SYNC→HOLD when the last chain flop is 1.
  - With HOLD_CYCLES=0, SYNC goes directly to RUN.
  - HOLD→RUN after HOLD_CYCLES counted cycles.
  - Any state→RST asynchronously when `a_reset` rises.
- `s_reset` is 1 in RST, SYNC and HOLD, and 0 only in RUN. It is driven from a flop, never from combinational decode.
- Assertion of `s_reset` is asynchronous; deassertion is synchronous.
- Hold counter width is clog2(HOLD_CYCLES+1), minimum 1 bit. It is cleared by `a_reset`.
- Channel i, sample path: `async_in[i]` → SYNC_STAGES-flop chain → `sample[i]` (the last stage).
  - The chain resets to RESET_VAL[i].
  - The chain runs in all non-RST states.
- Channel i, debounce counter `cnt[i]`, width clog2(DEBOUNCE_CYCLES+1), minimum 1 bit. Each edge in RUN:
  - If `sample`==`sync_out`: cnt←0.
  - Else if cnt==DEBOUNCE_CYCLES: `sync_out`←`sample`, cnt←0, and the matching pulse←1.
  - Else: cnt←cnt+1.
- `rise_pulse`/`fall_pulse` are registered. They default to 0 on every edge unless set by a flip, so each pulse is exactly one cycle wide. A pulse is asserted in the same cycle `sync_out` changes.
- Outside RUN:
  - `sync_out` is held at RESET_VAL.
  - cnt is held at 0.
  - Pulses are held at 0.
- A bounce that returns to the `sync_out` value before the count completes clears cnt and produces no output change.

## Timing
- Reset values of all outputs:
  - `s_reset`=1.
  - `sync_out`=RESET_VAL.
  - `rise_pulse`=0, `fall_pulse`=0.
  - All internal flops and counters 0, except the channel chains, which reset to RESET_VAL.
- Reset release: counting the first rising edge after `a_reset` falls as edge 1, `s_reset` is 0 after edge SYNC_STAGES+HOLD_CYCLES.
  - Defaults: 6 cycles.
  - An `a_reset` fall within the setup window may add one cycle.
- Input latency: `async_in` change meeting setup before edge k gives:
  - `sample` changes after edge k+SYNC_STAGES-1.
  - `sync_out` and the pulse change after edge k+SYNC_STAGES+DEBOUNCE_CYCLES.
- Minimum stable input width accepted is DEBOUNCE_CYCLES+1 cycles.
- If the first RUN edge sees `sample`≠RESET_VAL, it is processed normally. A pulse may therefore occur on the first RUN edge (D=0) or D+1 edges later.
- `a_reset` mid-operation, including a glitch shorter than one cycle:
  - Immediate asynchronous return to RST.
  - Outputs take reset values.
  - The full release sequence repeats.
- No ordering is guaranteed between channels changing on the same edge; each channel is independent.

## Test plan
- Reset release with defaults: drive `a_reset` high for 3 cycles, then low → `s_reset` stays 1 through edge 5 and is 0 after edge 6; `sync_out`=0 and pulses 0 throughout.
- Mid-operation reset: in RUN with `sync_out`=4'b0101, pulse `a_reset` for 2 ns between edges → `s_reset`=1 and `sync_out`=0 immediately, without waiting for a clock edge; `s_reset` falls again 6 edges after release.
- No-debounce latency (DEBOUNCE_CYCLES=0, SYNC_STAGES=2): `async_in[2]` 0→1 before edge k → `sync_out[2]`=1 and `rise_pulse[2]`=1 after edge k+2; `rise_pulse[2]`=0 after edge k+3; the other channels are unchanged.
- Debounce (DEBOUNCE_CYCLES=3, SYNC_STAGES=2):
  - A 3-cycle high glitch on `async_in[0]` → no change and no pulse.
  - A 4-cycle or longer high level on `async_in[0]` → `sync_out[0]` rises after edge k+5 with a one-cycle `rise_pulse[0]`.
  - A later 1→0 transition produces `fall_pulse[0]` only.
- Parameter sweep:
  - SYNC_STAGES=3, HOLD_CYCLES=0, CHANNELS=1 → release after edge 3.
  - RESET_VAL=1 with `async_in` held 1 → no pulse on entering RUN.
  - Simultaneous rises on all channels → all pulse on the same edge.
